// File: rtl/fetch_pc_gen.sv
// Fetch-stage program counter generator for an RV32I core.
// Holds the current fetch address and picks the next one by priority:
// trap entry, taken branch/jump, a redirect captured while fetch could not
// advance, then the sequential increment. A small BOOT/RUN/HALT machine
// gates fetch requests, and an accepted-fetch counter tracks throughput.
module fetch_pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             imem_ready_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    input  logic             trap_i,
    input  logic [XLEN-1:0]  trap_vec_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus_o,
    output logic             pc_valid_o,
    output logic             pend_valid_o,
    output logic             misaligned_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    localparam logic [XLEN-1:0]  INC_V   = XLEN'(INC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  pc_plus;
    logic [XLEN-1:0]  pend_pc;
    logic [XLEN-1:0]  pend_pc_next;
    logic             pend_valid;
    logic             pend_valid_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             adv;

    // A fetch is accepted only while running, not stalled, and memory is ready.
    assign adv = (state == RUN) && !stall_i && imem_ready_i;

    // Sequential successor; wraps naturally modulo 2^XLEN.
    assign pc_plus = pc + INC_V;

    // State register; BOOT is held only until the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: halt dominates resume when both are requested.
    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (halt_i) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (resume_i && !halt_i) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // Next-PC selection and pending-redirect bookkeeping, highest priority first.
    always_comb begin
        pc_next         = pc;
        pend_pc_next    = pend_pc;
        pend_valid_next = pend_valid;
        if (trap_i) begin
            // Trap entry overrides everything, even while stalled or halted.
            pc_next         = trap_vec_i;
            pend_valid_next = 1'b0;
        end else if (redirect_i && adv) begin
            pc_next         = redirect_pc_i;
            pend_valid_next = 1'b0;
        end else if (redirect_i) begin
            // Fetch cannot move now; remember the target, newest wins.
            pend_pc_next    = redirect_pc_i;
            pend_valid_next = 1'b1;
        end else if (pend_valid && adv) begin
            pc_next         = pend_pc;
            pend_valid_next = 1'b0;
        end else if (adv) begin
            pc_next         = pc_plus;
        end
    end

    // Accepted fetches are counted; a trap edge is not a fetch.
    always_comb begin
        cnt_next = cnt;
        if (adv && !trap_i) begin
            cnt_next = cnt + CNT_ONE;
        end
    end

    // PC, pending redirect and counter registers; reset drops any pending target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_VECTOR;
            pend_pc    <= '0;
            pend_valid <= 1'b0;
            cnt        <= '0;
        end else begin
            pc         <= pc_next;
            pend_pc    <= pend_pc_next;
            pend_valid <= pend_valid_next;
            cnt        <= cnt_next;
        end
    end

    assign pc_o         = pc;
    assign pc_plus_o    = pc_plus;
    assign pc_valid_o   = (state == RUN);
    assign pend_valid_o = pend_valid;
    // Misaligned targets are passed through; the exception is raised downstream.
    assign misaligned_o = |pc[1:0];
    assign fetch_cnt_o  = cnt;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: a table of per-edge stimulus records with
// hand-computed outputs, followed by an asynchronous-reset sequence.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        imem_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic [31:0] trap_vec_i;
    logic        halt_i;
    logic        resume_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_o;
    logic        pc_valid_o;
    logic        pend_valid_o;
    logic        misaligned_o;
    logic [31:0] fetch_cnt_o;

    int total = 0;
    int bad   = 0;

    fetch_pc_gen #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .INC(4),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .imem_ready_i(imem_ready_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .trap_i(trap_i),
        .trap_vec_i(trap_vec_i),
        .halt_i(halt_i),
        .resume_i(resume_i),
        .pc_o(pc_o),
        .pc_plus_o(pc_plus_o),
        .pc_valid_o(pc_valid_o),
        .pend_valid_o(pend_valid_o),
        .misaligned_o(misaligned_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        trap;
        logic [31:0] tvec;
        logic        halt;
        logic        resume;
        logic [31:0] epc;
        logic        evalid;
        logic        epend;
        logic        emis;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic stall, input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic trap, input logic [31:0] tvec,
                       input logic halt, input logic resume,
                       input logic [31:0] epc, input logic evalid, input logic epend,
                       input logic emis, input logic [31:0] ecnt);
        vec_t v;
        v.stall = stall; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.trap = trap; v.tvec = tvec; v.halt = halt; v.resume = resume;
        v.epc = epc; v.evalid = evalid; v.epend = epend; v.emis = emis; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step,
                         input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, step, got, want);
        end
    endtask

    task automatic check_all(input int step, input logic [31:0] epc, input logic evalid,
                             input logic epend, input logic emis, input logic [31:0] ecnt);
        logic [31:0] eplus;
        eplus = epc + 32'd4;
        check("pc", step, pc_o, epc);
        check("pc_plus", step, pc_plus_o, eplus);
        check("valid", step, {31'd0, pc_valid_o}, {31'd0, evalid});
        check("pend", step, {31'd0, pend_valid_o}, {31'd0, epend});
        check("misaligned", step, {31'd0, misaligned_o}, {31'd0, emis});
        check("cnt", step, fetch_cnt_o, ecnt);
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0; imem_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        trap_i = 1'b0; trap_vec_i = '0; halt_i = 1'b0; resume_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=0 got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   stall rdy redir rpc           trap tvec          halt res  epc           vld pend mis cnt
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0000, 1, 0, 0, 32'd0);  // BOOT -> RUN
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0004, 1, 0, 0, 32'd1);
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0008, 1, 0, 0, 32'd2);
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_000C, 1, 0, 0, 32'd3);
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0010, 1, 0, 0, 32'd4);
        add(1, 1, 1, 32'h200,        0, 32'h0,          0, 0, 32'h0000_0010, 1, 1, 0, 32'd4);  // stalled redirect
        add(1, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0010, 1, 1, 0, 32'd4);
        add(1, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0010, 1, 1, 0, 32'd4);
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0200, 1, 0, 0, 32'd5);  // pending applied
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0204, 1, 0, 0, 32'd6);
        add(1, 1, 1, 32'h250,        0, 32'h0,          0, 0, 32'h0000_0204, 1, 1, 0, 32'd6);
        add(1, 1, 0, 32'h0,          1, 32'h8000_0000,  0, 0, 32'h8000_0000, 1, 0, 0, 32'd6);  // trap clears pending
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h8000_0004, 1, 0, 0, 32'd7);
        add(0, 1, 1, 32'h300,        1, 32'h1000,       0, 0, 32'h0000_1000, 1, 0, 0, 32'd7);  // trap beats redirect
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_1004, 1, 0, 0, 32'd8);
        add(0, 1, 1, 32'h40,         0, 32'h0,          0, 0, 32'h0000_0040, 1, 0, 0, 32'd9);
        add(0, 1, 0, 32'h0,          0, 32'h0,          1, 0, 32'h0000_0044, 0, 0, 0, 32'd10); // halt edge still advances
        add(0, 1, 1, 32'h500,        0, 32'h0,          0, 0, 32'h0000_0044, 0, 1, 0, 32'd10);
        add(0, 1, 0, 32'h0,          0, 32'h0,          1, 1, 32'h0000_0044, 0, 1, 0, 32'd10); // halt wins
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0044, 0, 1, 0, 32'd10);
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 1, 32'h0000_0044, 1, 1, 0, 32'd10); // resume
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0500, 1, 0, 0, 32'd11);
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0504, 1, 0, 0, 32'd12);
        add(0, 1, 0, 32'h0,          0, 32'h0,          1, 0, 32'h0000_0508, 0, 0, 0, 32'd13);
        add(0, 1, 0, 32'h0,          1, 32'h600,        0, 0, 32'h0000_0600, 0, 0, 0, 32'd13); // trap in HALT
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 1, 32'h0000_0600, 1, 0, 0, 32'd13);
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0604, 1, 0, 0, 32'd14);
        add(0, 1, 1, 32'hFFFF_FFFC,  0, 32'h0,          0, 0, 32'hFFFF_FFFC, 1, 0, 0, 32'd15);
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0000, 1, 0, 0, 32'd16); // wrap
        add(0, 1, 1, 32'h102,        0, 32'h0,          0, 0, 32'h0000_0102, 1, 0, 1, 32'd17); // misaligned
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0106, 1, 0, 1, 32'd18);
        add(1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0106, 1, 0, 1, 32'd18);
        add(0, 0, 1, 32'h200,        0, 32'h0,          0, 0, 32'h0000_0106, 1, 1, 1, 32'd18); // not ready
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0200, 1, 0, 0, 32'd19);
        add(1, 1, 1, 32'h700,        0, 32'h0,          0, 0, 32'h0000_0200, 1, 1, 0, 32'd19);
        add(1, 1, 1, 32'h800,        0, 32'h0,          0, 0, 32'h0000_0200, 1, 1, 0, 32'd19); // newer overwrites
        add(0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0000_0800, 1, 0, 0, 32'd20);

        idle_inputs();
        rst = 1'b0;
        #2;
        check_all(-1, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all(-2, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            stall_i       = vecs[i].stall;
            imem_ready_i  = vecs[i].rdy;
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            trap_i        = vecs[i].trap;
            trap_vec_i    = vecs[i].tvec;
            halt_i        = vecs[i].halt;
            resume_i      = vecs[i].resume;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].epc, vecs[i].evalid, vecs[i].epend, vecs[i].emis, vecs[i].ecnt);
        end

        // Asynchronous reset in the middle of a stall with a redirect pending.
        idle_inputs();
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h900;
        @(posedge clk);
        #1;
        check_all(100, 32'h0000_0800, 1'b1, 1'b1, 1'b0, 32'd20);
        #2;
        rst = 1'b0;
        #1;
        check_all(101, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        check_all(102, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        check_all(103, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        check_all(104, 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);

        // Trap taken while still in BOOT moves straight to RUN.
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        trap_i     = 1'b1;
        trap_vec_i = 32'h0000_0C00;
        @(posedge clk);
        #1;
        check_all(105, 32'h0000_0C00, 1'b1, 1'b0, 1'b0, 32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        check_all(106, 32'h0000_0C04, 1'b1, 1'b0, 1'b0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
